// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to DMA_REG, stalls the CPU and copies one
// 256-byte page to the PPU OAM data port, one read/write pair per two ce cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_PORT = 16'h2004
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_aout,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mr,
    input  logic        cpu_mw,
    input  logic [7:0]  din,
    output logic [15:0] aout,
    output logic [7:0]  dout,
    output logic        mr,
    output logic        mw,
    output logic        cpu_pause,
    output logic        dma_busy,
    output logic        dma_done
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       parity_q, parity_d;
    logic       pause_q, pause_d;
    logic       done_q, done_d;

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        parity_d = parity_q;
        pause_d  = pause_q;
        done_d   = done_q;
        if (ce) begin
            parity_d = ~parity_q;
            done_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_mw && cpu_aout == DMA_REG) begin
                        page_d  = cpu_dout;
                        state_d = HALT;
                    end
                end
                // parity_q=1 now means the next cycle is even, which is where reads must land
                HALT:  state_d = parity_q ? READ : ALIGN;
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = din;
                    state_d = WRITE;
                end
                WRITE: begin
                    if (idx_q == 8'hFF) begin
                        idx_d   = 8'h00;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
            pause_d = (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            pause_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            pause_q  <= pause_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        aout = cpu_aout;
        dout = cpu_dout;
        mr   = cpu_mr;
        mw   = cpu_mw;
        case (state_q)
            HALT, ALIGN: begin
                mr = 1'b0;
                mw = 1'b0;
            end
            READ: begin
                aout = {page_q, idx_q};
                mr   = 1'b1;
                mw   = 1'b0;
            end
            WRITE: begin
                aout = OAM_PORT;
                dout = data_q;
                mr   = 1'b0;
                mw   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_pause = pause_q;
    assign dma_busy  = pause_q;
    assign dma_done  = done_q;
endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: passthrough vector table, then scoreboarded page copies
// covering both HALT parities, sparse ce, and reset mid-transfer.
module tb_oam_dma;
    logic        clk, reset_n, ce;
    logic [15:0] cpu_aout;
    logic [7:0]  cpu_dout;
    logic        cpu_mr, cpu_mw;
    logic [7:0]  din;
    logic [15:0] aout;
    logic [7:0]  dout;
    logic        mr, mw, cpu_pause, dma_busy, dma_done;

    int n_chk = 0;
    int n_fail = 0;

    oam_dma dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .cpu_aout(cpu_aout), .cpu_dout(cpu_dout), .cpu_mr(cpu_mr), .cpu_mw(cpu_mw),
        .din(din), .aout(aout), .dout(dout), .mr(mr), .mw(mw),
        .cpu_pause(cpu_pause), .dma_busy(dma_busy), .dma_done(dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: page $07 returns ~low byte, other pages a mixed pattern
    function automatic logic [7:0] mem(input logic [15:0] a);
        return (a[15:8] == 8'h07) ? ~a[7:0] : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction
    assign din = mem(aout);

    // Reference parity: toggles every ce cycle, 0 after reset
    logic par;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) par <= 1'b0;
        else if (ce) par <= ~par;
    end

    logic [15:0] rdq[$];
    logic [7:0]  wrq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_dma(input logic [7:0] pg, input bit even_halt, input int ce_per,
                          input int abort_at);
        int paused = 0, idle = 0, reads = 0, bad = 0, hold_bad = 0;
        bit seen_done = 0, aborted = 0;
        logic [27:0] prev = '0;
        bit pce = 1;
        logic [15:0] ea;
        ce = 1'b1; cpu_mw = 1'b0; cpu_mr = 1'b0; cpu_aout = 16'h0123; cpu_dout = 8'h00;
        step();
        // trigger parity is the complement of HALT parity
        for (int k = 0; k < 4 && par != even_halt; k++) step();
        cpu_aout = 16'h4014; cpu_mw = 1'b1; cpu_dout = pg;
        @(negedge clk);
        chk("trig_aout", aout, 16'h4014);
        chk("trig_mw", mw, 1'b1);
        chk("trig_pause", cpu_pause, 1'b0);
        step();
        cpu_aout = 16'hC0DE; cpu_mw = 1'b0; cpu_mr = 1'b0; cpu_dout = 8'hEE;
        for (int i = 0; i < 256; i++) begin
            ea = {pg, i[7:0]};
            rdq.push_back(ea);
            wrq.push_back(mem(ea));
        end
        for (int cyc = 0; cyc < 4000 && !seen_done && !aborted; cyc++) begin
            ce = (ce_per <= 1) || (cyc % ce_per == 0);
            @(negedge clk);
            if (cyc == 0) chk("pause_next", cpu_pause, 1'b1);
            if (dma_busy !== cpu_pause) bad++;
            if (!pce && prev !== {aout, dout, mr, mw, cpu_pause, 1'b0}) hold_bad++;
            if (ce) begin
                if (cpu_pause) begin
                    paused++;
                    if (dma_done) bad++;
                    if (mr && mw) bad++;
                    if (mr) begin
                        reads++;
                        chk("read_even", par, 1'b0);
                        if (rdq.size() == 0) chk("extra_read", aout, 16'hFFFF);
                        else chk("read_addr", aout, rdq.pop_front());
                        if (reads == abort_at + 1) begin
                            reset_n = 1'b0;
                            #1;
                            chk("abort_pause", cpu_pause, 1'b0);
                            chk("abort_aout", aout, 16'hC0DE);
                            chk("abort_strobes", {mr, mw}, 2'b00);
                            chk("abort_done", dma_done, 1'b0);
                            #1 reset_n = 1'b1;
                            aborted = 1;
                        end
                    end else if (mw) begin
                        chk("write_addr", aout, 16'h2004);
                        if (wrq.size() == 0) chk("extra_write", dout, 9'h100);
                        else chk("write_data", dout, wrq.pop_front());
                    end else begin
                        idle++;
                    end
                end else begin
                    chk("done_pulse", dma_done, 1'b1);
                    chk("done_aout", aout, 16'hC0DE);
                    seen_done = 1;
                end
            end
            prev = {aout, dout, mr, mw, cpu_pause, 1'b0};
            pce = ce;
            if (!seen_done) step();
        end
        chk("busy_eq_pause", bad, 0);
        chk("ce_low_hold", hold_bad, 0);
        if (aborted) begin
            step();
            @(negedge clk);
            chk("post_abort_pause", cpu_pause, 1'b0);
            chk("post_abort_done", dma_done, 1'b0);
            rdq.delete();
            wrq.delete();
            step();
        end else begin
            chk("done_seen", seen_done, 1'b1);
            chk("paused_len", paused, even_halt ? 514 : 513);
            chk("idle_cycles", idle, even_halt ? 2 : 1);
            chk("reads_total", reads, 256);
            chk("queues_empty", rdq.size() + wrq.size(), 0);
            ce = 1'b1;
            step();
            @(negedge clk);
            chk("done_one_cycle", dma_done, 1'b0);
            chk("after_pause", cpu_pause, 1'b0);
            step();
        end
    endtask

    typedef struct {
        logic        ce;
        logic [15:0] a;
        logic [7:0]  d;
        logic        r, w;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic        exp_r, exp_w, exp_pause;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h4013, 8'h11, 1'b0, 1'b1, 16'h4013, 8'h11, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 16'h4015, 8'h22, 1'b0, 1'b1, 16'h4015, 8'h22, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h4014, 8'h33, 1'b1, 1'b0, 16'h4014, 8'h33, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h4014, 8'h44, 1'b0, 1'b1, 16'h4014, 8'h44, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h0000, 8'h55, 1'b0, 1'b0, 16'h0000, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h3FFF, 8'h77, 1'b0, 1'b1, 16'h3FFF, 8'h77, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h2004, 8'h88, 1'b1, 1'b0, 16'h2004, 8'h88, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h1234, 8'h99, 1'b0, 1'b0, 16'h1234, 8'h99, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; ce = 1'b1;
        cpu_aout = 16'h4014; cpu_dout = 8'h5A; cpu_mr = 1'b0; cpu_mw = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pause", cpu_pause, 1'b0);
        chk("rst_busy", dma_busy, 1'b0);
        chk("rst_done", dma_done, 1'b0);
        chk("rst_aout", aout, 16'h4014);
        chk("rst_dout_mw", {dout, mr, mw}, {8'h5A, 1'b0, 1'b1});
        cpu_mw = 1'b0;
        #2 reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            ce = vecs[i].ce; cpu_aout = vecs[i].a; cpu_dout = vecs[i].d;
            cpu_mr = vecs[i].r; cpu_mw = vecs[i].w;
            @(negedge clk);
            chk("pt_aout", aout, vecs[i].exp_a);
            chk("pt_dout", dout, vecs[i].exp_d);
            chk("pt_mr", mr, vecs[i].exp_r);
            chk("pt_mw", mw, vecs[i].exp_w);
            chk("pt_pause", cpu_pause, vecs[i].exp_pause);
            step();
        end

        do_dma(8'h02, 1'b0, 1, -1);
        do_dma(8'h02, 1'b1, 1, -1);
        do_dma(8'h07, 1'b0, 1, -1);
        do_dma(8'h40, 1'b1, 3, -1);
        do_dma(8'h20, 1'b0, 1, 100);
        do_dma(8'h20, 1'b0, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
